// File: rtl/receive_slot_dispatcher_if.sv
`default_nettype none
// ============================================================================
//  Module      : receive_slot_dispatcher_if
//  Description : Bundle between the UDP payload parser, the receive slots and
//                the slot dispatcher.
//                Parser side : in_data, in_data_enable, in_start, in_last,
//                              in_error, in_ipv4_flags, in_ipv4_identification
//                Slot side   : slot_ready (in); slot_data, slot_data_enable,
//                              slot_good_packet, slot_bad_packet,
//                              slot_ipv4_flags, slot_ipv4_identification (out)
//                Status      : busy, drop_count
//                The master modport is the environment, the slave modport is
//                the dispatcher.
//  Revision    : 1.0 - initial release
// ============================================================================
interface receive_slot_dispatcher_if #(
  parameter int SLOT_COUNT = 4
);
  logic [7:0]            in_data;
  logic                  in_data_enable;
  logic                  in_start;
  logic                  in_last;
  logic                  in_error;
  logic [15:0]           in_ipv4_flags;
  logic [15:0]           in_ipv4_identification;
  logic [SLOT_COUNT-1:0] slot_ready;

  logic [7:0]            slot_data;
  logic [SLOT_COUNT-1:0] slot_data_enable;
  logic [SLOT_COUNT-1:0] slot_good_packet;
  logic [SLOT_COUNT-1:0] slot_bad_packet;
  logic [15:0]           slot_ipv4_flags;
  logic [15:0]           slot_ipv4_identification;
  logic                  busy;
  logic [15:0]           drop_count;

  modport master (
    output in_data, in_data_enable, in_start, in_last, in_error,
           in_ipv4_flags, in_ipv4_identification, slot_ready,
    input  slot_data, slot_data_enable, slot_good_packet, slot_bad_packet,
           slot_ipv4_flags, slot_ipv4_identification, busy, drop_count
  );

  modport slave (
    input  in_data, in_data_enable, in_start, in_last, in_error,
           in_ipv4_flags, in_ipv4_identification, slot_ready,
    output slot_data, slot_data_enable, slot_good_packet, slot_bad_packet,
           slot_ipv4_flags, slot_ipv4_identification, busy, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/receive_slot_dispatcher.sv
`default_nettype none
// ============================================================================
//  Module      : receive_slot_dispatcher
//  Description : Steers UDP payload bytes from the parser into one of
//                SLOT_COUNT receive slots. Each packet is written to the
//                lowest-index idle, unreserved slot and closed with a one-cycle
//                good (commit) or bad (discard) pulse two cycles after the
//                terminating byte. Packets that find no slot are swallowed
//                and counted in drop_count.
//  Ports       : clock - single rising-edge clock
//                reset - synchronous active-high reset
//                bus   - receive_slot_dispatcher_if.slave (parser inputs,
//                        slot_ready, slot write/pulse/metadata outputs, busy,
//                        drop_count); all outputs are registered
//  Revision    : 1.0 - initial release
// ============================================================================
module receive_slot_dispatcher #(
  parameter int SLOT_COUNT  = 4,
  parameter int MAX_PAYLOAD = 1024
) (
  input wire logic                   clock,
  input wire logic                   reset,
  receive_slot_dispatcher_if.slave   bus
);

  localparam int IDX_W = $clog2(SLOT_COUNT);
  localparam int BC_W  = $clog2(MAX_PAYLOAD + 1);
  localparam logic [BC_W-1:0]       MAX_BC   = BC_W'(MAX_PAYLOAD);
  localparam logic [SLOT_COUNT-1:0] ONE_SLOT = {{(SLOT_COUNT-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FORWARD = 2'd1,
    S_DISCARD = 2'd2
  } state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      slot_idx_q;
  logic [BC_W-1:0]       byte_count_q;
  logic [SLOT_COUNT-1:0] reserved_q;
  logic [1:0]            rel_cnt_q [SLOT_COUNT];

  // Terminating decision is taken one cycle before the pulse so that the
  // pulse trails the final slot write by one cycle. The slot index is kept
  // separately because a back-to-back packet may already have re-targeted
  // slot_idx_q by the time the pulse goes out.
  logic                  pend_good_q;
  logic                  pend_bad_q;
  logic [IDX_W-1:0]      pend_idx_q;

  logic [7:0]            slot_data_q;
  logic [SLOT_COUNT-1:0] slot_data_enable_q;
  logic [SLOT_COUNT-1:0] slot_good_packet_q;
  logic [SLOT_COUNT-1:0] slot_bad_packet_q;
  logic [15:0]           slot_ipv4_flags_q;
  logic [15:0]           slot_ipv4_identification_q;
  logic                  busy_q;
  logic [15:0]           drop_count_q;

  logic [SLOT_COUNT-1:0] w_avail;
  logic [IDX_W-1:0]      w_sel_idx;
  logic                  w_any_avail;
  logic [SLOT_COUNT-1:0] w_sel_onehot;
  logic [SLOT_COUNT-1:0] w_cur_onehot;
  logic [SLOT_COUNT-1:0] w_pend_onehot;

  assign w_avail       = bus.slot_ready & ~reserved_q;
  assign w_sel_onehot  = ONE_SLOT << w_sel_idx;
  assign w_cur_onehot  = ONE_SLOT << slot_idx_q;
  assign w_pend_onehot = ONE_SLOT << pend_idx_q;

  // Lowest-index available slot: scan downwards so the last hit wins.
  always_comb begin
    w_sel_idx   = '0;
    w_any_avail = 1'b0;
    for (int k = SLOT_COUNT - 1; k >= 0; k--) begin
      if (w_avail[k]) begin
        w_sel_idx   = IDX_W'(k);
        w_any_avail = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q                    <= S_IDLE;
      slot_idx_q                 <= '0;
      byte_count_q               <= '0;
      reserved_q                 <= '0;
      for (int k = 0; k < SLOT_COUNT; k++) rel_cnt_q[k] <= 2'd0;
      pend_good_q                <= 1'b0;
      pend_bad_q                 <= 1'b0;
      pend_idx_q                 <= '0;
      slot_data_q                <= 8'd0;
      slot_data_enable_q         <= '0;
      slot_good_packet_q         <= '0;
      slot_bad_packet_q          <= '0;
      slot_ipv4_flags_q          <= 16'd0;
      slot_ipv4_identification_q <= 16'd0;
      busy_q                     <= 1'b0;
      drop_count_q               <= 16'd0;
    end else begin
      slot_data_enable_q <= '0;
      slot_good_packet_q <= pend_good_q ? w_pend_onehot : '0;
      slot_bad_packet_q  <= pend_bad_q  ? w_pend_onehot : '0;
      pend_good_q        <= 1'b0;
      pend_bad_q         <= 1'b0;

      // Hold the reservation for 3 cycles past the pulse: the slot only
      // drops slot_ready through its own register after it sees the pulse.
      for (int k = 0; k < SLOT_COUNT; k++) begin
        if ((pend_good_q || pend_bad_q) && (pend_idx_q == IDX_W'(k))) begin
          rel_cnt_q[k] <= 2'd3;
        end else if (rel_cnt_q[k] != 2'd0) begin
          rel_cnt_q[k] <= rel_cnt_q[k] - 2'd1;
          if (rel_cnt_q[k] == 2'd1) reserved_q[k] <= 1'b0;
        end
      end

      if (bus.in_data_enable) begin
        case (state_q)
          S_IDLE: begin
            if (bus.in_start) begin
              if (w_any_avail) begin
                slot_idx_q                 <= w_sel_idx;
                pend_idx_q                 <= w_sel_idx;
                reserved_q[w_sel_idx]      <= 1'b1;
                slot_ipv4_flags_q          <= bus.in_ipv4_flags;
                slot_ipv4_identification_q <= bus.in_ipv4_identification;
                if (bus.in_error) begin
                  // Corrupt first byte: slot is claimed only to receive the
                  // discard pulse; nothing is written.
                  byte_count_q <= '0;
                  pend_bad_q   <= 1'b1;
                  state_q      <= bus.in_last ? S_IDLE : S_DISCARD;
                  busy_q       <= !bus.in_last;
                end else begin
                  byte_count_q       <= BC_W'(1);
                  slot_data_q        <= bus.in_data;
                  slot_data_enable_q <= w_sel_onehot;
                  pend_good_q        <= bus.in_last;
                  state_q            <= bus.in_last ? S_IDLE : S_FORWARD;
                  busy_q             <= !bus.in_last;
                end
              end else begin
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
                state_q <= bus.in_last ? S_IDLE : S_DISCARD;
                busy_q  <= !bus.in_last;
              end
            end
          end

          S_FORWARD: begin
            pend_idx_q <= slot_idx_q;
            if (bus.in_start) begin
              // A new packet started before the current one ended: close the
              // current one as bad and swallow the newcomer.
              pend_bad_q <= 1'b1;
              if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
              state_q <= bus.in_last ? S_IDLE : S_DISCARD;
              busy_q  <= !bus.in_last;
            end else if (bus.in_error || (byte_count_q == MAX_BC)) begin
              // Error or one byte beyond the slot depth: never written.
              pend_bad_q <= 1'b1;
              state_q    <= bus.in_last ? S_IDLE : S_DISCARD;
              busy_q     <= !bus.in_last;
            end else begin
              byte_count_q       <= byte_count_q + BC_W'(1);
              slot_data_q        <= bus.in_data;
              slot_data_enable_q <= w_cur_onehot;
              if (bus.in_last) begin
                pend_good_q <= 1'b1;
                state_q     <= S_IDLE;
                busy_q      <= 1'b0;
              end
            end
          end

          S_DISCARD: begin
            if (bus.in_last) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end

          default: begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.slot_data                = slot_data_q;
  assign bus.slot_data_enable         = slot_data_enable_q;
  assign bus.slot_good_packet         = slot_good_packet_q;
  assign bus.slot_bad_packet          = slot_bad_packet_q;
  assign bus.slot_ipv4_flags          = slot_ipv4_flags_q;
  assign bus.slot_ipv4_identification = slot_ipv4_identification_q;
  assign bus.busy                     = busy_q;
  assign bus.drop_count               = drop_count_q;

endmodule
`default_nettype wire

// File: doc/receive_slot_dispatcher.md
RECEIVE_SLOT_DISPATCHER -- requirements
Module: receive_slot_dispatcher

Interface
REQ-001 SHALL have parameter SLOT_COUNT, default 4, number of downstream receive slots (2..8).
REQ-002 SHALL have parameter MAX_PAYLOAD, default 1024, maximum bytes per packet (equals slot FIFO depth).
REQ-003 SHALL have port clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_data  input  8  UDP payload byte from the parser.
REQ-006 SHALL have port in_data_enable  input  1  in_data valid; qualifies in_start, in_last and in_error.
REQ-007 SHALL have port in_start  input  1  first payload byte of a packet.
REQ-008 SHALL have port in_last  input  1  last payload byte of a packet.
REQ-009 SHALL have port in_error  input  1  packet is corrupt (checksum, length or MAC error).
REQ-010 SHALL have port in_ipv4_flags  input  16  flags of the current packet; valid with in_start.
REQ-011 SHALL have port in_ipv4_identification  input  16  identification of the current packet; valid with in_start.
REQ-012 SHALL have port slot_ready  input  SLOT_COUNT  per-slot idle indication.
REQ-013 SHALL have port slot_data  output  8  byte to all slots.
REQ-014 SHALL have port slot_data_enable  output  SLOT_COUNT  one-hot or zero write strobe.
REQ-015 SHALL have port slot_good_packet  output  SLOT_COUNT  one-cycle commit pulse.
REQ-016 SHALL have port slot_bad_packet  output  SLOT_COUNT  one-cycle discard pulse.
REQ-017 SHALL have port slot_ipv4_flags  output  16  latched flags of the packet in flight.
REQ-018 SHALL have port slot_ipv4_identification  output  16  latched identification of the packet in flight.
REQ-019 SHALL have port busy  output  1  packet in flight (S_FORWARD or S_DISCARD).
REQ-020 SHALL have port drop_count  output  16  saturating count of packets discarded for lack of a slot.

Function
REQ-021 SHALL implement states S_IDLE, S_FORWARD and S_DISCARD; all outputs SHALL be registered.
REQ-022 SHALL treat a slot as available when slot_ready[k]=1 and the slot is not reserved.
REQ-023 In S_IDLE, a byte with in_start SHALL select the lowest-index available slot, latch its index, latch in_ipv4_flags and in_ipv4_identification into slot_ipv4_*, reserve the slot, clear the byte counter and forward the byte.
REQ-024 A forwarded byte received in cycle T SHALL appear on slot_data, with slot_data_enable[k]=1, in cycle T+1.
REQ-025 In S_IDLE, a byte with in_start and no available slot SHALL pulse nothing to the slots, increment drop_count (saturating at 0xFFFF) and go to S_DISCARD.
REQ-026 In S_IDLE, bytes without in_start SHALL be ignored.
REQ-027 In S_FORWARD, each byte SHALL be forwarded; the byte counter (width clog2(MAX_PAYLOAD+1)) SHALL count forwarded bytes.
REQ-028 A terminating condition in cycle T SHALL produce a single slot_good_packet[k] or slot_bad_packet[k] pulse in cycle T+2, one cycle after the last slot write.
REQ-029 in_last without in_error SHALL be terminating and SHALL produce a good pulse, and the byte SHALL be forwarded.
REQ-030 in_error SHALL be terminating and SHALL produce a bad pulse, and the byte SHALL NOT be forwarded; this holds when in_error coincides with in_last.
REQ-031 Byte number MAX_PAYLOAD+1 SHALL be terminating and SHALL produce a bad pulse, and the byte SHALL NOT be forwarded.
REQ-032 After in_error or overflow without in_last, the block SHALL go to S_DISCARD; after in_last it SHALL go to S_IDLE.
REQ-033 in_start in S_FORWARD SHALL abort the current packet with a bad pulse, count a drop and enter S_DISCARD, unless in_last is also set in the same cycle.
REQ-034 A byte carrying both in_start and in_last SHALL be handled as a one-byte packet; a good pulse SHALL follow in T+2.
REQ-035 S_DISCARD SHALL forward nothing and SHALL return to S_IDLE on a byte with in_last.
REQ-036 slot_ipv4_* SHALL hold their values until the next packet is accepted, and SHALL remain stable through the commit pulse cycle.
REQ-037 A slot's reservation SHALL remain set from selection until 3 cycles after its pulse, which covers the registered slot_ready deassertion latency.
REQ-038 A new in_start in the cycle after in_last SHALL be accepted into a different available slot.

Reset
REQ-039 While reset=1 at a clock edge, the block SHALL set state to S_IDLE and clear all reservations, counters and slot_ipv4_*.
REQ-040 While reset=1 at a clock edge, the block SHALL set slot_data_enable, slot_good_packet, slot_bad_packet, slot_data, busy and drop_count to 0.
REQ-041 Reset mid-packet SHALL issue no pulse for the aborted packet.

Verification
REQ-042 SHALL cover: all slots ready, 3-byte packet 0xA1,0xA2,0xA3 with id 0x1234 -> slot 0 written in T+1..T+3, good[0] in T+4, slot_ipv4_identification=0x1234.
REQ-043 SHALL cover: back-to-back packets with no idle cycle -> second packet goes to slot 1, good[0] and good[1] each pulse once.
REQ-044 SHALL cover: slot_ready=0 for all slots, 5-byte packet -> no strobes, drop_count=1, busy high until in_last.
REQ-045 SHALL cover: in_error on byte 3 of 10 -> 2 bytes written, bad[0] at error cycle+2, remaining bytes ignored.
REQ-046 SHALL cover: 1025-byte packet with MAX_PAYLOAD=1024 -> 1024 writes, bad pulse, no good pulse.
REQ-047 SHALL cover: reset asserted at byte 4 -> all outputs 0 next cycle, no pulse, next packet uses slot 0.
